drawing_sequencer: RTL

Parametrised successor to the drawing control FSM. It arbitrates move, draw, erase and clear requests from the input path, buffers requests that arrive while a VGA task is running, and sequences the MOVE → WAIT → CLEAN animation cycle. The frame delay is either a programmable cycle count or synchronised to vertical sync. A watchdog returns the sequencer to IDLE if the datapath never reports completion. It sits between the mouse/button decoder and the drawing datapath, which consumes `oState` and `oStart`.

---
 rtl/drawing_sequencer_if.sv | 26 ++
 rtl/drawing_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/drawing_sequencer_if.sv
// Request/status bundle between the input decoder (master) and the drawing sequencer (slave).
// Signal names match the sequencer's pin names so both sides read the same.
interface drawing_sequencer_if;
    logic       iMove;
    logic       iBtnL;
    logic       iBtnR;
    logic       iClear;
    logic       iDone;
    logic       iVsync;
    logic [2:0] oState;
    logic       oStart;
    logic       oBusy;
    logic [3:0] oPending;
    logic       oTimeout;
    logic       oFault;

    modport master (
        output iMove, iBtnL, iBtnR, iClear, iDone, iVsync,
        input  oState, oStart, oBusy, oPending, oTimeout, oFault
    );

    modport slave (
        input  iMove, iBtnL, iBtnR, iClear, iDone, iVsync,
        output oState, oStart, oBusy, oPending, oTimeout, oFault
    );
endinterface

// File: rtl/drawing_sequencer.sv
// Arbitrates move/draw/erase/clear requests, buffers them while busy, and runs the
// MOVE -> WAIT -> CLEAN animation cycle with a per-state watchdog back to IDLE.
module drawing_sequencer #(
    parameter int WAIT_CYCLES    = 2,
    parameter int SYNC_MODE      = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                iClk,
    input logic                iReset,
    drawing_sequencer_if.slave bus
);
    localparam int WAIT_W_RAW = $clog2(WAIT_CYCLES + 1);
    localparam int WAIT_W     = (WAIT_W_RAW < 1) ? 1 : WAIT_W_RAW;
    localparam int WD_W_RAW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_W       = (WD_W_RAW < 1) ? 1 : WD_W_RAW;
    localparam bit WD_EN      = (TIMEOUT_CYCLES != 0);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CLEAN = 3'd3,
        ST_DRAW  = 3'd4,
        ST_ERASE = 3'd5,
        ST_CLEAR = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        pending_q, pending_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              vsync_q;
    logic              start_q, start_d;
    logic              timeout_q, timeout_d;
    logic              fault_q, fault_d;

    logic [3:0] live_req;
    logic [3:0] req;
    logic [3:0] grant;
    logic       done_ok;
    logic       vsync_rise;

    assign live_req   = {bus.iClear, bus.iBtnR, bus.iBtnL, bus.iMove};
    assign req        = pending_q | live_req;
    // start_q marks the first cycle of a task state, where completion is masked
    assign done_ok    = bus.iDone & ~start_q;
    assign vsync_rise = bus.iVsync & ~vsync_q;

    // Fixed priority: lowest index (move) wins
    assign grant[0] = req[0];
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_grant
            assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | live_req;
        wait_cnt_d = '0;
        wd_cnt_d   = wd_cnt_q;
        start_d    = 1'b0;
        timeout_d  = 1'b0;
        fault_d    = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    pending_d = req & ~grant;
                    if (grant[0])      state_d = ST_MOVE;
                    else if (grant[1]) state_d = ST_DRAW;
                    else if (grant[2]) state_d = ST_ERASE;
                    else               state_d = ST_CLEAR;
                end
            end
            ST_MOVE: begin
                if (done_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (SYNC_MODE != 0) begin
                    if (vsync_rise) state_d = ST_CLEAN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_CLEAN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_CLEAN, ST_DRAW, ST_ERASE, ST_CLEAR: begin
                if (done_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog only fires when nothing else would move the state this cycle
        if (WD_EN && (state_q != ST_IDLE) && (state_d == state_q) && (wd_cnt_q == WD_LAST)) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
            fault_d   = 1'b1;
        end

        if (state_d != state_q) begin
            wd_cnt_d = '0;
        end else if (WD_EN && (state_q != ST_IDLE)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        start_d = (state_d != state_q) && (state_d != ST_IDLE) && (state_d != ST_WAIT);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            wait_cnt_q <= '0;
            wd_cnt_q   <= '0;
            vsync_q    <= 1'b0;
            start_q    <= 1'b0;
            timeout_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            wait_cnt_q <= wait_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            vsync_q    <= bus.iVsync;
            start_q    <= start_d;
            timeout_q  <= timeout_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.oState   = state_q;
    assign bus.oStart   = start_q;
    assign bus.oBusy    = (state_q != ST_IDLE);
    assign bus.oPending = pending_q;
    assign bus.oTimeout = timeout_q;
    assign bus.oFault   = fault_q;
endmodule
